fifo_packer: RTL

- Downstream consumer of the team's `fifo` block.
- Pops WIDTH-bit items from the FIFO read port and packs COUNT consecutive items into one WIDTH*COUNT-bit word.
- Presents each packed word on a valid/ready output interface.
- A flush input forces early emission of a partially filled word, so trailing data is never stranded.

---
 rtl/fifo_packer.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_packer.sv
// Packs COUNT consecutive WIDTH-bit items popped from a first-word-fall-through
// FIFO into one wide word presented on a valid/ready interface; flush emits a partial word.
module fifo_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [WIDTH-1:0]           fifo_rd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*COUNT-1:0]     out_data,
  output logic [$clog2(COUNT+1)-1:0] out_count
);

  localparam int unsigned IW = $clog2(COUNT);
  localparam int unsigned CW = $clog2(COUNT + 1);
  localparam int unsigned DW = WIDTH * COUNT;

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_OUTPUT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] pack_q, pack_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          pop;
  logic [CW-1:0] held;
  logic          last_lane;

  assign fifo_rd_en = (state_q == ST_FILL) && !fifo_empty && !rst;
  assign pop        = fifo_rd_en;
  assign held       = CW'(idx_q) + CW'(pop);
  assign last_lane  = (idx_q == IW'(COUNT - 1));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      ST_FILL: begin
        if (pop) begin
          pack_d[idx_q*WIDTH +: WIDTH] = fifo_rd_data;
          idx_d = idx_q + IW'(1);
        end
        // The word is copied out on entry, so the packing register is free to
        // clear here rather than at the handshake; nothing observable differs.
        if ((pop && last_lane) || (flush && (held != '0))) begin
          state_d     = ST_OUTPUT;
          out_valid_d = 1'b1;
          out_data_d  = pack_d;
          out_count_d = held;
          idx_d       = '0;
          pack_d      = '0;
        end
      end
      ST_OUTPUT: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_FILL;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
